ilkn_tx_framer: RTL and testbench

- Parametrised successor of the Interlaken TX framing stage.
- Builds the 64b/67b word stream for one lane from a valid/ready user interface, paced by a programmable fractional gearbox slot generator.
- Inserts metaframe words: sync, scrambler state, skip and diagnostic.
- Adds burst/idle control words carrying SOP, EOP format and channel, and enforces a maximum burst length.
- Sits between the user packet source and the scrambler/gearbox.

---
 rtl/ilkn_pkg.sv | 43 ++++
 rtl/ilkn_tx_framer_gb_slot.sv | 36 +++
 rtl/ilkn_tx_framer.sv | 167 ++++++++++++++++
 tb/tb_ilkn_tx_framer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ilkn_pkg.sv
// Shared constants and helpers for the Interlaken TX framing path.
// Framing words, 64b/67b headers and the burst/idle control-word layout.
package ilkn_pkg;

   localparam logic [63:0] SYNC_WORD  = 64'h78F6_78F6_78F6_78F6;
   localparam logic [63:0] SCRAM_WORD = 64'h2800_0000_0000_0000;
   localparam logic [63:0] SKIP_WORD  = 64'h1E1E_1E1E_1E1E_1E1E;
   localparam logic [63:0] DIAG_WORD  = 64'h6400_0000_0000_0000;

   localparam logic [1:0] HDR_DATA = 2'b01;
   localparam logic [1:0] HDR_CTRL = 2'b10;

   localparam int CW_CTRL_BIT = 63;
   localparam int CW_TYPE_BIT = 62;
   localparam int CW_SOP_BIT  = 61;
   localparam int CW_EOP_LSB  = 57;
   localparam int CW_CH_LSB   = 32;
   localparam int DIAG_LS_LSB = 32;

   // Closed: no burst; open: data may flow; eop: burst closed, EOP word owed.
   typedef enum logic [1:0] {
      ST_CLOSED,
      ST_OPEN,
      ST_EOP
   } burst_st_t;

   // CRC24 is left zero; it is filled further down the lane.
   function automatic logic [63:0] ctrl_word(
      input logic       sop,
      input logic [3:0] eop_fmt,
      input logic [7:0] ch
   );
      logic [63:0] w;
      w = '0;
      w[CW_CTRL_BIT] = 1'b1;
      w[CW_TYPE_BIT] = 1'b1;
      w[CW_SOP_BIT] = sop;
      w[CW_EOP_LSB +: 4] = eop_fmt;
      w[CW_CH_LSB +: 8] = ch;
      return w;
   endfunction

endpackage

// File: rtl/ilkn_tx_framer_gb_slot.sv
// Fractional slot pacer: GB_NUM slot pulses in every GB_DEN cycles.
// Registered output; accumulator wraps modulo GB_DEN.
module ilkn_gb_slot_gen #(
   parameter int GB_NUM = 22,
   parameter int GB_DEN = 67
)(
   input  logic USER_CLK,
   input  logic SYSTEM_RESET_N,
   output logic slot_q
);

   localparam int AW = $clog2(GB_DEN) + 1;
   localparam logic [AW:0] NUM_W = (AW + 1)'(GB_NUM);
   localparam logic [AW:0] DEN_W = (AW + 1)'(GB_DEN);

   logic [AW-1:0] acc;
   logic [AW:0]   sum;
   logic [AW:0]   wrap;

   assign sum  = {1'b0, acc} + NUM_W;
   assign wrap = sum - DEN_W;

   always_ff @(posedge USER_CLK) begin
      if (!SYSTEM_RESET_N) begin
         acc    <= '0;
         slot_q <= 1'b0;
      end else if (sum >= DEN_W) begin
         acc    <= wrap[AW-1:0];
         slot_q <= 1'b1;
      end else begin
         acc    <= sum[AW-1:0];
         slot_q <= 1'b0;
      end
   end

endmodule

// File: rtl/ilkn_tx_framer.sv
// Interlaken TX framer: metaframe framing words, burst/idle control words
// and user data, one 64b/67b word per gearbox slot.
module ilkn_tx_framer
   import ilkn_pkg::*;
#(
   parameter int META_FRAME_LEN = 16,
   parameter int GB_NUM         = 22,
   parameter int GB_DEN         = 67,
   parameter int BURST_MAX      = 8,
   parameter int CH_W           = 8
)(
   input  logic            USER_CLK,
   input  logic            SYSTEM_RESET_N,
   input  logic [63:0]     DATA_IN,
   input  logic            DATA_SOP,
   input  logic            DATA_EOP,
   input  logic [2:0]      DATA_EOP_BYTES,
   input  logic [CH_W-1:0] DATA_CHANNEL,
   input  logic            DATA_TO_SEND,
   output logic            DATA_IN_READY,
   input  logic [1:0]      LINK_STATUS,
   output logic [63:0]     DATA_OUT,
   output logic [1:0]      HEADER_OUT,
   output logic            DATA_VALID,
   output logic            FRAME_START,
   output logic            PROTO_ERR
);

   localparam int PW = $clog2(META_FRAME_LEN);
   localparam int CW = $clog2(BURST_MAX + 1);
   localparam logic [PW-1:0] POS_LAST = PW'(META_FRAME_LEN - 1);
   localparam logic [PW-1:0] POS_SKIP = PW'(2);
   localparam logic [CW-1:0] CNT_MAX  = CW'(BURST_MAX);

   logic slot_q;

   ilkn_gb_slot_gen #(
      .GB_NUM(GB_NUM),
      .GB_DEN(GB_DEN)
   ) u_slot (
      .USER_CLK(USER_CLK),
      .SYSTEM_RESET_N(SYSTEM_RESET_N),
      .slot_q(slot_q)
   );

   burst_st_t     st_q, st_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    eb_q, eb_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic          fresh_q, fresh_d;
   logic          perr_d;
   logic [63:0]   dout_d;
   logic [1:0]    hdr_d;
   logic          vld_d, fs_d;
   logic          is_pay, xfer;
   logic [7:0]    ch_in8, ch_cur8;

   assign ch_in8  = 8'(DATA_CHANNEL);
   assign ch_cur8 = 8'(ch_q);
   assign is_pay  = (pos_q > POS_SKIP) && (pos_q != POS_LAST);

   // Ready depends on registered state only.
   assign DATA_IN_READY = slot_q && is_pay && (st_q == ST_OPEN)
                          && (cnt_q < CNT_MAX);
   assign xfer = DATA_TO_SEND && DATA_IN_READY;

   always_comb begin
      st_d    = st_q;
      pos_d   = pos_q;
      cnt_d   = cnt_q;
      eb_d    = eb_q;
      ch_d    = ch_q;
      fresh_d = fresh_q;
      perr_d  = PROTO_ERR;
      dout_d  = '0;
      hdr_d   = '0;
      vld_d   = 1'b0;
      fs_d    = 1'b0;
      if (slot_q) begin
         vld_d = 1'b1;
         hdr_d = HDR_CTRL;
         pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
         unique case (1'b1)
            pos_q == '0: begin
               dout_d = SYNC_WORD;
               fs_d   = 1'b1;
            end
            pos_q == PW'(1): dout_d = SCRAM_WORD;
            pos_q == POS_SKIP: dout_d = SKIP_WORD;
            pos_q == POS_LAST: begin
               dout_d = DIAG_WORD;
               dout_d[DIAG_LS_LSB +: 2] = LINK_STATUS;
            end
            default: begin
               unique case (1'b1)
                  st_q == ST_EOP: begin
                     dout_d = ctrl_word(DATA_TO_SEND, {1'b1, eb_q},
                                        DATA_TO_SEND ? ch_in8 : 8'h00);
                     st_d = ST_CLOSED;
                     if (DATA_TO_SEND) begin
                        st_d    = ST_OPEN;
                        cnt_d   = '0;
                        ch_d    = DATA_CHANNEL;
                        fresh_d = 1'b1;
                     end
                  end
                  st_q == ST_CLOSED && DATA_TO_SEND: begin
                     dout_d  = ctrl_word(1'b1, 4'h0, ch_in8);
                     st_d    = ST_OPEN;
                     cnt_d   = '0;
                     ch_d    = DATA_CHANNEL;
                     fresh_d = 1'b1;
                     if (!DATA_SOP) perr_d = 1'b1;
                  end
                  st_q == ST_OPEN && cnt_q == CNT_MAX: begin
                     dout_d = ctrl_word(1'b0, 4'h0, ch_cur8);
                     cnt_d  = '0;
                  end
                  xfer: begin
                     hdr_d   = HDR_DATA;
                     dout_d  = DATA_IN;
                     cnt_d   = cnt_q + 1'b1;
                     fresh_d = 1'b0;
                     // SOP is legal only on the first word of the burst.
                     if (DATA_SOP && !fresh_q) perr_d = 1'b1;
                     if (DATA_EOP) begin
                        st_d = ST_EOP;
                        eb_d = DATA_EOP_BYTES;
                     end
                  end
                  default: dout_d = ctrl_word(1'b0, 4'h0, 8'h00);
               endcase
            end
         endcase
      end
   end

   always_ff @(posedge USER_CLK) begin
      if (!SYSTEM_RESET_N) begin
         st_q        <= ST_CLOSED;
         pos_q       <= '0;
         cnt_q       <= '0;
         eb_q        <= '0;
         ch_q        <= '0;
         fresh_q     <= 1'b0;
         PROTO_ERR   <= 1'b0;
         DATA_OUT    <= '0;
         HEADER_OUT  <= '0;
         DATA_VALID  <= 1'b0;
         FRAME_START <= 1'b0;
      end else begin
         st_q        <= st_d;
         pos_q       <= pos_d;
         cnt_q       <= cnt_d;
         eb_q        <= eb_d;
         ch_q        <= ch_d;
         fresh_q     <= fresh_d;
         PROTO_ERR   <= perr_d;
         DATA_OUT    <= dout_d;
         HEADER_OUT  <= hdr_d;
         DATA_VALID  <= vld_d;
         FRAME_START <= fs_d;
      end
   end

endmodule

// File: tb/tb_ilkn_tx_framer.sv
// Self-checking bench for ilkn_tx_framer: directed packets plus random
// traffic against a slot-level behavioural model, with a 1/1 gearbox copy.
module tb_ilkn_tx_framer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [63:0] din = '0;
   logic sop = 1'b0, eop = 1'b0, send = 1'b0;
   logic [2:0] eb = '0;
   logic [7:0] ch = '0;
   logic [1:0] ls = 2'b11;

   logic rdy, vld, fs, perr;
   logic [63:0] dout;
   logic [1:0] hdr;
   logic f_rdy, f_vld, f_fs, f_perr;
   logic [63:0] f_dout;
   logic [1:0] f_hdr;

   int total = 0;
   int bad = 0;
   bit gaps = 0;
   bit rand_ls = 0;

   always #5 clk = ~clk;

   ilkn_tx_framer dut (
      .USER_CLK(clk), .SYSTEM_RESET_N(rst_n),
      .DATA_IN(din), .DATA_SOP(sop), .DATA_EOP(eop),
      .DATA_EOP_BYTES(eb), .DATA_CHANNEL(ch),
      .DATA_TO_SEND(send), .DATA_IN_READY(rdy),
      .LINK_STATUS(ls), .DATA_OUT(dout), .HEADER_OUT(hdr),
      .DATA_VALID(vld), .FRAME_START(fs), .PROTO_ERR(perr)
   );

   ilkn_tx_framer #(
      .META_FRAME_LEN(5), .GB_NUM(1), .GB_DEN(1)
   ) dut_fast (
      .USER_CLK(clk), .SYSTEM_RESET_N(rst_n),
      .DATA_IN(64'h0), .DATA_SOP(1'b0), .DATA_EOP(1'b0),
      .DATA_EOP_BYTES(3'd0), .DATA_CHANNEL(8'd0),
      .DATA_TO_SEND(1'b0), .DATA_IN_READY(f_rdy),
      .LINK_STATUS(ls), .DATA_OUT(f_dout), .HEADER_OUT(f_hdr),
      .DATA_VALID(f_vld), .FRAME_START(f_fs), .PROTO_ERR(f_perr)
   );

   typedef struct {
      int j; int pos; int cnt;
      bit open; bit pend; bit fresh; bit perr;
      logic [2:0] b; logic [7:0] c;
   } mst_t;

   typedef struct {
      logic [63:0] d; logic [1:0] h;
      bit v; bit fs; bit pe; bit rdy; bit xfer;
   } mout_t;

   typedef struct {
      logic [63:0] d; logic s; logic e; logic [2:0] b; logic [7:0] c;
   } pw_t;

   typedef struct { logic [1:0] h; logic [63:0] d; logic f; } ow_t;

   mst_t ms = '{default: 0};
   mst_t fms = '{default: 0};
   pw_t pq[$];
   ow_t got[$];
   ow_t fgot[$];

   function automatic logic [63:0] cw(input bit s, input logic [3:0] f,
                                      input logic [7:0] c);
      return 64'hC000_0000_0000_0000 | (64'(s) << 61) | (64'(f) << 57)
             | (64'(c) << 32);
   endfunction

   // One gearbox slot carries one word; slot k happens when floor(k*N/D) steps.
   function automatic void mstep(
      input mst_t s, input int num, input int den, input int len,
      input int bmax, input logic v, input logic sp, input logic ep,
      input logic [2:0] b, input logic [7:0] c, input logic [63:0] d,
      input logic [1:0] l, output mst_t n, output mout_t o);
      bit slot, pay;
      n = s;
      o = '{default: 0};
      slot = (s.j > 0) && ((s.j * num) / den != ((s.j - 1) * num) / den);
      pay = (s.pos >= 3) && (s.pos < len - 1);
      o.rdy = slot && pay && s.open && (s.cnt < bmax);
      n.j = s.j + 1;
      if (slot) begin
         o.v = 1; o.h = 2'b10;
         n.pos = (s.pos + 1) % len;
         if (s.pos == 0) begin o.d = 64'h78F6_78F6_78F6_78F6; o.fs = 1; end
         else if (s.pos == 1) o.d = 64'h2800_0000_0000_0000;
         else if (s.pos == 2) o.d = 64'h1E1E_1E1E_1E1E_1E1E;
         else if (s.pos == len - 1) o.d = 64'h6400_0000_0000_0000 | (64'(l) << 32);
         else if (s.pend) begin
            o.d = cw(v, {1'b1, s.b}, v ? c : 8'h00);
            n.pend = 0;
            if (v) begin n.open = 1; n.cnt = 0; n.c = c; n.fresh = 1; end
         end else if (!s.open && v) begin
            o.d = cw(1, 4'h0, c);
            n.open = 1; n.cnt = 0; n.c = c; n.fresh = 1;
            if (!sp) n.perr = 1;
         end else if (s.open && s.cnt == bmax) begin
            o.d = cw(0, 4'h0, s.c); n.cnt = 0;
         end else if (o.rdy && v) begin
            o.h = 2'b01; o.d = d; o.xfer = 1;
            n.cnt = s.cnt + 1; n.fresh = 0;
            if (sp && !s.fresh) n.perr = 1;
            if (ep) begin n.open = 0; n.pend = 1; n.b = b; end
         end else o.d = cw(0, 4'h0, 8'h00);
      end
      o.pe = n.perr;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_got(input string nm, input int i, input logic [1:0] h,
                          input logic [63:0] d);
      chk({nm, "_data"}, (i < got.size()) ? got[i].d : ~d, d);
      chk({nm, "_hdr"}, (i < got.size()) ? 64'(got[i].h) : 64'(~h), 64'(h));
   endtask

   task automatic chk_fgot(input string nm, input int i, input logic [63:0] d);
      chk(nm, (i < fgot.size()) ? fgot[i].d : ~d, d);
   endtask

   task automatic drive();
      if (pq.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
         send = 1; din = pq[0].d; sop = pq[0].s; eop = pq[0].e;
         eb = pq[0].b; ch = pq[0].c;
      end else begin
         send = 0; din = {$urandom, $urandom}; sop = 1'($urandom);
         eop = 1'($urandom); eb = 3'($urandom); ch = 8'($urandom);
      end
      ls = rand_ls ? 2'($urandom) : 2'b11;
   endtask

   task automatic cycle();
      mst_t n1, n2;
      mout_t o1, o2;
      bit r1;
      mstep(ms, 22, 67, 16, 8, send, sop, eop, eb, ch, din, ls, n1, o1);
      mstep(fms, 1, 1, 5, 8, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 64'd0, ls, n2, o2);
      if (rst_n) begin
         chk("ready", 64'(rdy), 64'(o1.rdy));
         chk("f_ready", 64'(f_rdy), 64'(o2.rdy));
      end else begin
         r1 = 0;
         n1 = '{default: 0}; n2 = '{default: 0};
         o1 = '{default: 0}; o2 = '{default: 0};
         o1.rdy = r1;
      end
      @(posedge clk);
      #1;
      chk("dout", dout, o1.d);
      chk("hdr", 64'(hdr), 64'(o1.h));
      chk("valid", 64'(vld), 64'(o1.v));
      chk("frame_start", 64'(fs), 64'(o1.fs));
      chk("proto_err", 64'(perr), 64'(o1.pe));
      chk("f_dout", f_dout, o2.d);
      chk("f_valid", 64'(f_vld), 64'(o2.v));
      chk("f_hdr", 64'(f_hdr), 64'(o2.h));
      chk("f_frame_start", 64'(f_fs), 64'(o2.fs));
      if (rst_n && o1.xfer && pq.size() > 0) void'(pq.pop_front());
      if (vld) got.push_back('{hdr, dout, fs});
      if (f_vld) fgot.push_back('{f_hdr, f_dout, f_fs});
      ms = n1;
      fms = n2;
   endtask

   task automatic run(input int n);
      repeat (n) begin drive(); cycle(); end
   endtask

   task automatic do_reset();
      rst_n = 0;
      pq.delete();
      run(2);
      rst_n = 1;
      got.delete();
      fgot.delete();
   endtask

   task automatic add_pkt(input int n, input logic [7:0] c,
                          input logic [2:0] b, input logic [63:0] base);
      for (int k = 0; k < n; k++)
         pq.push_back('{base + 64'(k), k == 0, k == n - 1, b, c});
   endtask

   initial begin
      int cnt;
      // Idle framing: slot rate, word order and the 1/1 gearbox copy.
      do_reset();
      run(10);
      for (int w = 0; w < 3; w++) begin
         cnt = 0;
         repeat (67) begin drive(); cycle(); cnt += int'(vld); end
         chk("slots_per_67", 64'(cnt), 64'd22);
      end
      chk_got("idle_sync", 0, 2'b10, 64'h78F6_78F6_78F6_78F6);
      chk("idle_fs", (got.size() > 0) ? 64'(got[0].f) : 64'd0, 64'd1);
      chk_got("idle_scram", 1, 2'b10, 64'h2800_0000_0000_0000);
      chk_got("idle_skip", 2, 2'b10, 64'h1E1E_1E1E_1E1E_1E1E);
      for (int i = 3; i < 15; i++)
         chk_got("idle_word", i, 2'b10, 64'hC000_0000_0000_0000);
      chk_got("idle_diag", 15, 2'b10, 64'h6400_0003_0000_0000);
      chk_got("idle_resync", 16, 2'b10, 64'h78F6_78F6_78F6_78F6);
      chk_fgot("fast_sync", 0, 64'h78F6_78F6_78F6_78F6);
      chk_fgot("fast_scram", 1, 64'h2800_0000_0000_0000);
      chk_fgot("fast_skip", 2, 64'h1E1E_1E1E_1E1E_1E1E);
      chk_fgot("fast_idle", 3, 64'hC000_0000_0000_0000);
      chk_fgot("fast_diag", 4, 64'h6400_0003_0000_0000);
      chk_fgot("fast_resync", 5, 64'h78F6_78F6_78F6_78F6);

      // Three-word packet on channel 7, five bytes on the EOP word.
      do_reset();
      add_pkt(3, 8'h07, 3'd5, 64'h1111_0000_0000_0000);
      run(40);
      chk_got("p3_sop", 3, 2'b10, 64'hE000_0007_0000_0000);
      for (int i = 0; i < 3; i++)
         chk_got("p3_data", 4 + i, 2'b01, 64'h1111_0000_0000_0000 + 64'(i));
      chk_got("p3_eop", 7, 2'b10, 64'hDA00_0000_0000_0000);
      chk_got("p3_idle", 8, 2'b10, 64'hC000_0000_0000_0000);
      chk("p3_perr", 64'(perr), 64'd0);

      // Twenty words: continuation words and a burst across framing.
      do_reset();
      add_pkt(20, 8'h03, 3'd2, 64'h3000_0000_0000_0000);
      run(120);
      chk_got("p20_first", 4, 2'b01, 64'h3000_0000_0000_0000);
      chk_got("p20_cont1", 12, 2'b10, 64'hC000_0003_0000_0000);
      chk_got("p20_w9", 13, 2'b01, 64'h3000_0000_0000_0008);
      chk_got("p20_diag", 15, 2'b10, 64'h6400_0003_0000_0000);
      chk_got("p20_sync", 16, 2'b10, 64'h78F6_78F6_78F6_78F6);
      chk_got("p20_w11", 19, 2'b01, 64'h3000_0000_0000_000A);
      chk_got("p20_cont2", 25, 2'b10, 64'hC000_0003_0000_0000);
      chk_got("p20_w20", 29, 2'b01, 64'h3000_0000_0000_0013);
      chk_got("p20_eop", 30, 2'b10, 64'hD400_0000_0000_0000);

      // Back-to-back packets share one EOP+SOP control word.
      do_reset();
      add_pkt(2, 8'h01, 3'd0, 64'h5100_0000_0000_0000);
      add_pkt(2, 8'h02, 3'd4, 64'h5200_0000_0000_0000);
      run(40);
      chk_got("b2b_sop", 3, 2'b10, 64'hE000_0001_0000_0000);
      chk_got("b2b_join", 6, 2'b10, 64'hF000_0002_0000_0000);
      chk_got("b2b_data", 7, 2'b01, 64'h5200_0000_0000_0000);
      chk_got("b2b_eop", 9, 2'b10, 64'hD800_0000_0000_0000);

      // Missing SOP, sticky error, then a reset in the middle of a burst.
      do_reset();
      pq.push_back('{64'h7700_0000_0000_0000, 1'b0, 1'b1, 3'd3, 8'h05});
      run(30);
      chk_got("nosop_ctrl", 3, 2'b10, 64'hE000_0005_0000_0000);
      chk("nosop_perr", 64'(perr), 64'd1);
      add_pkt(10, 8'h06, 3'd1, 64'h7800_0000_0000_0000);
      run(30);
      chk("perr_sticky", 64'(perr), 64'd1);
      rst_n = 0;
      pq.delete();
      drive();
      cycle();
      chk("rst_valid", 64'(vld), 64'd0);
      chk("rst_dout", dout, 64'd0);
      chk("rst_hdr", 64'(hdr), 64'd0);
      chk("rst_perr", 64'(perr), 64'd0);
      rst_n = 1;
      got.delete();
      fgot.delete();
      run(20);
      chk_got("rst_sync", 0, 2'b10, 64'h78F6_78F6_78F6_78F6);

      // Random traffic, gaps and link status, with one reset part way.
      do_reset();
      gaps = 1;
      rand_ls = 1;
      for (int t = 0; t < 4000; t++) begin
         if (t == 2000) do_reset();
         if (pq.size() < 4 && $urandom_range(0, 9) == 0)
            add_pkt(int'($urandom_range(1, 20)), 8'($urandom),
                    3'($urandom), {$urandom, 32'h0});
         drive();
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
